mac_accumulator: RTL
====================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter: LEN_W, default 4, width of the length field; the block accumulates up to 2^LEN_W products; accumulator width ACC_W = 8+LEN_W (12 at default).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-005 Port: len  input  LEN_W  product count minus one (N = len+1, 1..2^LEN_W); sampled with start.
REQ-006 Port: prod  input  8  unsigned 8-bit product from the upstream 4x4 multiplier stage.
REQ-007 Port: prod_valid  input  1  prod holds a valid product this cycle.
REQ-008 Port: prod_ready  output  1  block accepts a product this cycle.
REQ-009 Port: acc_out  output  ACC_W  running, then final, unsigned sum.
REQ-010 Port: acc_valid  output  1  acc_out holds a final sum.
REQ-011 Port: acc_ready  input  1  downstream consumes the final sum.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACC and DONE; all outputs SHALL be registered or decoded from state only (no input-to-output combinational path).
REQ-014 IDLE: start=1 at a rising edge SHALL latch len, clear acc_out to 0, clear the beat counter to 0, and enter ACC; start=0 SHALL hold IDLE with acc_out unchanged.
REQ-015 prod_ready SHALL be 1 exactly in ACC; acc_valid SHALL be 1 exactly in DONE; busy SHALL be 1 in ACC and DONE.
REQ-016 A beat is accepted at a rising edge where prod_valid=1 and prod_ready=1; prod_valid=1 with prod_ready=0 SHALL be ignored, and prod_valid=0 cycles in ACC SHALL neither add nor count.
REQ-017 On each accepted beat acc_out SHALL become acc_out + zero-extended prod at that edge, and the beat counter SHALL increment by one; throughput is one product per cycle.
REQ-018 The accepted beat with counter equal to the latched len SHALL be the last: at that same edge the sum updates and the state enters DONE, so acc_valid rises in the cycle after the last beat (latency 1 cycle).
REQ-019 Arithmetic is unsigned; ACC_W is sized so 2^LEN_W * 225 never overflows; no saturation or wrap logic is required.
REQ-020 DONE: acc_out and acc_valid SHALL hold stable until acc_valid=1 and acc_ready=1 at a rising edge, which returns to IDLE with acc_valid=0; acc_out SHALL retain the final sum in IDLE until the next start.
REQ-021 start SHALL be ignored in ACC and DONE; a new accumulation needs at least one IDLE cycle, so start asserted in the DONE-handshake cycle is not taken.
REQ-022 len changes outside the start-sampling edge SHALL have no effect on an accumulation in progress.

Reset
REQ-023 reset=0 SHALL immediately, without waiting for clk, force state IDLE, acc_out=0, beat counter=0, acc_valid=0, prod_ready=0, busy=0.
REQ-024 Reset asserted mid-ACC or mid-DONE SHALL discard the partial or final sum; after release the block SHALL wait in IDLE for start.
REQ-025 The first rising edge after reset release SHALL be able to sample start.

Verification
REQ-026 Reset: drive reset=0 between clock edges during ACC with acc_out=45 -> acc_out=0, busy=0, prod_ready=0 before the next edge.
REQ-027 Basic: start with len=3, then products 15,30,45,225 on consecutive cycles with prod_valid=1 -> acc_valid=1 one cycle after the 4th beat, acc_out=315.
REQ-028 Maximum: len=15, 16 beats of 225 -> acc_out=3600 (0xE10), no overflow.
REQ-029 Bubbles: len=1, products 10 (valid=1), 99 (valid=0), 20 (valid=1) -> acc_out=30, the 99 is not counted.
REQ-030 Backpressure: len=0, product 7, then acc_ready=0 for 5 cycles with start pulsed -> acc_valid=1 and acc_out=7 held all 5 cycles, start ignored; acc_ready=1 -> IDLE next cycle, acc_valid=0, acc_out stays 7.

Source files
------------

// File: rtl/mac_accumulator.sv
// Unsigned multiply-accumulate back end: sums len+1 8-bit products into an
// (8+LEN_W)-bit accumulator and hands the final sum downstream.
module mac_accumulator #(
  parameter  int LEN_W = 4,
  localparam int ACC_W = 8 + LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  // Handshakes: a transfer happens at a rising edge where valid and ready
  // are both 1; ready/valid here are decoded from state only.
  assign prod_ready = (state == ACC);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc_out <= '0;
      cnt     <= '0;
      len_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            acc_out <= '0;
            cnt     <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          if (prod_valid) begin
            acc_out <= acc_out + ACC_W'(prod);
            cnt     <= cnt + LEN_W'(1);
            // The counter may wrap on the final beat at max length; harmless.
            if (cnt == len_q) state <= DONE;
          end
        end
        DONE: begin
          if (acc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
